// File: rtl/camera_capture_decim.sv
// camera_capture_decim
//   Captures an OV7670-style byte stream (two bytes per pixel), converts each pixel
//   to the frame-buffer format, decimates by DECIM in X and Y and drives the
//   dual-port RAM write port.
//
//   Optional feature macro: CAPTURE_TEST_PATTERN_EN (adds input test_pattern that
//   replaces camera pixels with 8 vertical colour bars).
//
//   Ports:
//     PCLK            camera pixel clock, all logic on posedge
//     RST_N           asynchronous active-low reset (synchronously released)
//     VSYNC           frame sync, high = vertical blanking
//     HREF            line valid, high = active bytes
//     D[7:0]          camera data byte
//     capture_en      arm capture, sampled at frame start only
//     test_pattern    (CAPTURE_TEST_PATTERN_EN only) select colour bars
//     DP_RAM_data_in  converted pixel
//     DP_RAM_addr_in  write address
//     DP_RAM_regW     one-cycle write strobe
//     frame_done      one-cycle pulse at end of captured frame
//     line_err        one-cycle pulse on malformed line
//     busy            high while armed or capturing
module camera_capture_decim #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned DECIM    = 2,
  parameter int unsigned FORMAT   = 0,
  parameter int unsigned PIX_W    = 12,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              PCLK,
  input  logic              RST_N,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [7:0]        D,
  input  logic              capture_en,
`ifdef CAPTURE_TEST_PATTERN_EN
  input  logic              test_pattern,
`endif
  output logic [PIX_W-1:0]  DP_RAM_data_in,
  output logic [ADDR_W-1:0] DP_RAM_addr_in,
  output logic              DP_RAM_regW,
  output logic              frame_done,
  output logic              line_err,
  output logic              busy
);

  localparam int unsigned MEM_DEPTH = (H_ACTIVE / DECIM) * (V_ACTIVE / DECIM);
  localparam int unsigned COL_W     = $clog2(H_ACTIVE + 1);
  localparam int unsigned ROW_W     = $clog2(V_ACTIVE + 1) + 1;
  localparam int unsigned DM_W      = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [ADDR_W-1:0] MemDepthA = ADDR_W'(MEM_DEPTH);
  localparam logic [COL_W-1:0]  HActiveC  = COL_W'(H_ACTIVE);
  localparam logic [DM_W-1:0]   DecimLast = DM_W'(DECIM - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StActive} state_e;

  state_e            state_q;
  logic [1:0]        rst_sync_q;
  logic              rst_n_sync;
  logic              vsync_q, href_q;
  logic              phase_q;
  logic [7:0]        byte0_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [DM_W-1:0]   col_mod_q, row_mod_q;
  logic              vsync_fall, vsync_rise;
  logic [11:0]       conv12;
  logic [PIX_W-1:0]  pix_sel;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_sync = rst_sync_q[1];

  assign vsync_fall = vsync_q & ~VSYNC;
  assign vsync_rise = ~vsync_q & VSYNC;

  // Pixel conversion: byte0 is registered, byte1 is the live D.
  always_comb begin
    conv12 = '0;
    if (FORMAT == 0) begin
      conv12 = {byte0_q[3:0], D};
    end else if (FORMAT == 1) begin
      conv12 = {byte0_q[7:4], byte0_q[2:0], D[7], D[4:1]};
    end else begin
      conv12 = {4'h0, byte0_q[7:5], byte0_q[2:0], D[4:3]};
    end
  end

`ifdef CAPTURE_TEST_PATTERN_EN
  logic [2:0]       bar_idx;
  logic [PIX_W-1:0] bar_pix;

  always_comb begin
    bar_idx = 3'(((32'(col_q)) * 8) / H_ACTIVE);
    bar_pix = '0;
    if (FORMAT == 2) begin
      unique case (bar_idx)
        3'd0: bar_pix = PIX_W'(8'hFF);
        3'd1: bar_pix = PIX_W'(8'hFC);
        3'd2: bar_pix = PIX_W'(8'h1F);
        3'd3: bar_pix = PIX_W'(8'h1C);
        3'd4: bar_pix = PIX_W'(8'hE3);
        3'd5: bar_pix = PIX_W'(8'hE0);
        3'd6: bar_pix = PIX_W'(8'h03);
        default: bar_pix = '0;
      endcase
    end else begin
      unique case (bar_idx)
        3'd0: bar_pix = PIX_W'(12'hFFF);
        3'd1: bar_pix = PIX_W'(12'hFF0);
        3'd2: bar_pix = PIX_W'(12'h0FF);
        3'd3: bar_pix = PIX_W'(12'h0F0);
        3'd4: bar_pix = PIX_W'(12'hF0F);
        3'd5: bar_pix = PIX_W'(12'hF00);
        3'd6: bar_pix = PIX_W'(12'h00F);
        default: bar_pix = '0;
      endcase
    end
    pix_sel = test_pattern ? bar_pix : conv12[PIX_W-1:0];
  end
`else
  assign pix_sel = conv12[PIX_W-1:0];
`endif

  always_ff @(posedge PCLK or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state_q        <= StIdle;
      vsync_q        <= 1'b0;
      href_q         <= 1'b0;
      phase_q        <= 1'b0;
      byte0_q        <= '0;
      col_q          <= '0;
      row_q          <= '0;
      col_mod_q      <= '0;
      row_mod_q      <= '0;
      DP_RAM_data_in <= '0;
      DP_RAM_addr_in <= '0;
      DP_RAM_regW    <= 1'b0;
      frame_done     <= 1'b0;
      line_err       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      vsync_q     <= VSYNC;
      href_q      <= HREF;
      DP_RAM_regW <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      // Address advances after the strobe cycle; writes are only issued below
      // MEM_DEPTH, so this saturates at MEM_DEPTH.
      if (DP_RAM_regW) DP_RAM_addr_in <= DP_RAM_addr_in + 1'b1;

      unique case (state_q)
        StIdle: begin
          if (capture_en) begin
            state_q <= StArmed;
            busy    <= 1'b1;
          end
        end
        StArmed: begin
          if (!capture_en) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end else if (vsync_fall) begin
            state_q   <= StActive;
            phase_q   <= 1'b0;
            col_q     <= '0;
            col_mod_q <= '0;
            row_q     <= '0;
            row_mod_q <= '0;
          end
        end
        StActive: begin
          if (vsync_rise) begin
            // Frame end also aborts any line in flight, silently.
            frame_done     <= 1'b1;
            DP_RAM_addr_in <= '0;
            phase_q        <= 1'b0;
            col_q          <= '0;
            col_mod_q      <= '0;
            state_q        <= capture_en ? StArmed : StIdle;
            busy           <= capture_en;
          end else if (HREF) begin
            phase_q <= ~phase_q;
            if (!phase_q) begin
              byte0_q <= D;
            end else begin
              col_q     <= col_q + 1'b1;
              col_mod_q <= (col_mod_q == DecimLast) ? '0 : col_mod_q + 1'b1;
              if (col_mod_q == '0 && row_mod_q == '0 && DP_RAM_addr_in < MemDepthA) begin
                DP_RAM_regW    <= 1'b1;
                DP_RAM_data_in <= pix_sel;
              end
            end
          end else begin
            phase_q <= 1'b0;
            if (href_q) begin
              line_err  <= phase_q | (col_q != HActiveC);
              col_q     <= '0;
              col_mod_q <= '0;
              row_q     <= row_q + 1'b1;
              row_mod_q <= (row_mod_q == DecimLast) ? '0 : row_mod_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camera_capture_decim.sv
module tb_camera_capture_decim;

  logic        PCLK = 1'b0;
  logic        RST_N, VSYNC, HREF, capture_en;
  logic [7:0]  D;
`ifdef CAPTURE_TEST_PATTERN_EN
  logic        test_pattern = 1'b0;
`endif

  logic [11:0] f0_data, f1_data;
  logic [7:0]  f2_data;
  logic [7:0]  f0_addr, f1_addr, f2_addr;
  logic        f0_we, f1_we, f2_we;
  logic        f0_fd, f1_fd, f2_fd;
  logic        f0_le, f1_le, f2_le;
  logic        f0_busy, f1_busy, f2_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 PCLK = ~PCLK;

  camera_capture_decim #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(2), .FORMAT(0), .PIX_W(12),
                         .ADDR_W(8)) u_f0 (
    .PCLK(PCLK), .RST_N(RST_N), .VSYNC(VSYNC), .HREF(HREF), .D(D), .capture_en(capture_en),
`ifdef CAPTURE_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .DP_RAM_data_in(f0_data), .DP_RAM_addr_in(f0_addr), .DP_RAM_regW(f0_we),
    .frame_done(f0_fd), .line_err(f0_le), .busy(f0_busy));

  camera_capture_decim #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(2), .FORMAT(1), .PIX_W(12),
                         .ADDR_W(8)) u_f1 (
    .PCLK(PCLK), .RST_N(RST_N), .VSYNC(VSYNC), .HREF(HREF), .D(D), .capture_en(capture_en),
`ifdef CAPTURE_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .DP_RAM_data_in(f1_data), .DP_RAM_addr_in(f1_addr), .DP_RAM_regW(f1_we),
    .frame_done(f1_fd), .line_err(f1_le), .busy(f1_busy));

  camera_capture_decim #(.H_ACTIVE(8), .V_ACTIVE(4), .DECIM(2), .FORMAT(2), .PIX_W(8),
                         .ADDR_W(8)) u_f2 (
    .PCLK(PCLK), .RST_N(RST_N), .VSYNC(VSYNC), .HREF(HREF), .D(D), .capture_en(capture_en),
`ifdef CAPTURE_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .DP_RAM_data_in(f2_data), .DP_RAM_addr_in(f2_addr), .DP_RAM_regW(f2_we),
    .frame_done(f2_fd), .line_err(f2_le), .busy(f2_busy));

  // Write log and pulse counters for the FORMAT 0 instance.
  logic [7:0]  wr_addr[$];
  logic [11:0] wr_data[$];
  int fd_cnt = 0;
  int le_cnt = 0;

  always @(negedge PCLK) begin
    if (f0_we) begin
      wr_addr.push_back(f0_addr);
      wr_data.push_back(f0_data);
    end
    if (f0_fd) fd_cnt++;
    if (f0_le) le_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    HREF = 1'b1;
    D    = b;
    step();
  endtask

  task automatic line(input int n, input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 0; i < n; i++) put((i % 2 == 0) ? b0 : b1);
    HREF = 1'b0;
    repeat (3) step();
  endtask

  task automatic vsync_pulse();
    HREF  = 1'b0;
    VSYNC = 1'b1;
    repeat (3) step();
    VSYNC = 1'b0;
    repeat (2) step();
  endtask

  int base, fbase, lbase;

  initial begin
    RST_N = 1'b0; VSYNC = 1'b0; HREF = 1'b0; D = 8'h00; capture_en = 1'b0;
    repeat (3) step();
    RST_N = 1'b1;
    repeat (4) step();
    chk("reset_regW", 32'(f0_we), 32'd0);
    chk("reset_addr", 32'(f0_addr), 32'd0);
    chk("reset_data", 32'(f0_data), 32'd0);
    chk("reset_busy", 32'(f0_busy), 32'd0);
    chk("reset_frame_done", 32'(f0_fd), 32'd0);
    chk("reset_line_err", 32'(f0_le), 32'd0);

    // Full small frame: 8 writes of 0xABC at 0..7.
    base = wr_addr.size(); fbase = fd_cnt; lbase = le_cnt;
    capture_en = 1'b1;
    step();
    chk("armed_busy", 32'(f0_busy), 32'd1);
    vsync_pulse();
    for (int l = 0; l < 4; l++) line(16, 8'h0A, 8'hBC);
    capture_en = 1'b0;
    VSYNC = 1'b1;
    step();
    chk("frame_done_pulse", 32'(f0_fd), 32'd1);
    step();
    chk("frame_done_one_cycle", 32'(f0_fd), 32'd0);
    chk("addr_wrapped", 32'(f0_addr), 32'd0);
    chk("busy_after_frame", 32'(f0_busy), 32'd0);
    chk("frame_write_count", 32'(wr_addr.size() - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (base + i < wr_addr.size()) begin
        chk($sformatf("frame_addr%0d", i), 32'(wr_addr[base + i]), 32'(i));
        chk($sformatf("frame_data%0d", i), 32'(wr_data[base + i]), 32'hABC);
      end
    end
    chk("frame_done_count", 32'(fd_cnt - fbase), 32'd1);
    chk("frame_line_err_count", 32'(le_cnt - lbase), 32'd0);
    VSYNC = 1'b0;
    repeat (2) step();

    // Formats and malformed line.
    base = wr_addr.size(); lbase = le_cnt;
    capture_en = 1'b1;
    step();
    vsync_pulse();
    put(8'hF8);
    chk("f1_no_regW_on_byte0", 32'(f1_we), 32'd0);
    put(8'h1F);
    chk("f1_regW", 32'(f1_we), 32'd1);
    chk("f1_data", 32'(f1_data), 32'hF0F);
    for (int i = 2; i < 16; i++) put((i % 2 == 0) ? 8'hF8 : 8'h1F);
    HREF = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 7; i++) put(8'h55);
    HREF = 1'b0;
    step();
    chk("line_err_pulse", 32'(f0_le), 32'd1);
    step();
    chk("line_err_one_cycle", 32'(f0_le), 32'd0);
    step();
    put(8'hFF);
    chk("f2_no_regW_on_byte0", 32'(f2_we), 32'd0);
    put(8'hE0);
    chk("f2_regW", 32'(f2_we), 32'd1);
    chk("f2_data", 32'(f2_data), 32'hFC);
    chk("after_err_regW", 32'(f0_we), 32'd1);
    chk("after_err_addr", 32'(f0_addr), 32'd4);
    for (int i = 2; i < 16; i++) put((i % 2 == 0) ? 8'hFF : 8'hE0);
    HREF = 1'b0;
    repeat (3) step();
    capture_en = 1'b0;
    VSYNC = 1'b1;
    step();
    chk("fmt_frame_done", 32'(f0_fd), 32'd1);
    chk("fmt_line_err_count", 32'(le_cnt - lbase), 32'd1);
    chk("fmt_write_count", 32'(wr_addr.size() - base), 32'd8);
    VSYNC = 1'b0;
    repeat (2) step();

    // Arming mid-frame: nothing written until the next VSYNC fall.
    base = wr_addr.size();
    vsync_pulse();
    line(16, 8'h0A, 8'hBC);
    capture_en = 1'b1;
    step();
    chk("arm_mid_busy", 32'(f0_busy), 32'd1);
    line(16, 8'h0A, 8'hBC);
    line(16, 8'h0A, 8'hBC);
    chk("arm_mid_no_writes", 32'(wr_addr.size() - base), 32'd0);
    vsync_pulse();
    line(16, 8'h0A, 8'hBC);
    capture_en = 1'b0;
    for (int l = 1; l < 4; l++) line(16, 8'h0A, 8'hBC);
    chk("drop_mid_busy", 32'(f0_busy), 32'd1);
    chk("drop_mid_writes", 32'(wr_addr.size() - base), 32'd8);
    VSYNC = 1'b1;
    step();
    chk("drop_frame_done", 32'(f0_fd), 32'd1);
    chk("drop_busy_low", 32'(f0_busy), 32'd0);
    VSYNC = 1'b0;
    repeat (2) step();

    // Overflow: 6 lines into a 4-line buffer.
    base = wr_addr.size();
    capture_en = 1'b1;
    step();
    vsync_pulse();
    for (int l = 0; l < 6; l++) line(16, 8'h0A, 8'hBC);
    chk("ovf_addr_saturated", 32'(f0_addr), 32'd8);
    chk("ovf_write_count", 32'(wr_addr.size() - base), 32'd8);
    if (wr_addr.size() > base) chk("ovf_last_addr", 32'(wr_addr[$]), 32'd7);
    capture_en = 1'b0;
    VSYNC = 1'b1;
    step();
    chk("ovf_addr_wrap", 32'(f0_addr), 32'd0);
    VSYNC = 1'b0;
    repeat (2) step();

    // Asynchronous reset mid-line.
    capture_en = 1'b1;
    step();
    vsync_pulse();
    put(8'h0A);
    put(8'hBC);
    chk("pre_reset_regW", 32'(f0_we), 32'd1);
    put(8'h0A);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_addr", 32'(f0_addr), 32'd0);
    chk("async_data", 32'(f0_data), 32'd0);
    chk("async_busy", 32'(f0_busy), 32'd0);
    chk("async_regW", 32'(f0_we), 32'd0);
    capture_en = 1'b0;
    step();
    RST_N = 1'b1;
    base = wr_addr.size();
    for (int i = 0; i < 8; i++) put((i % 2 == 0) ? 8'h0A : 8'hBC);
    HREF = 1'b0;
    step();
    chk("post_reset_idle_busy", 32'(f0_busy), 32'd0);
    chk("post_reset_no_writes", 32'(wr_addr.size() - base), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/camera_capture_decim.md
Name: camera_capture_decim

Overview:
- Parametrised successor to the single-format camera capture stage; sits between the OV7670-style camera pins (PCLK, HREF, VSYNC, D[7:0]) and the frame-buffer dual-port RAM write port.
- Assembles two-byte pixels, converts them to the buffer pixel format and decimates by an integer factor in X and Y.
- Generates the RAM write strobe and address, synchronised to frame boundaries, with frame-done and line-error reporting.

Parameters:
- H_ACTIVE, 640, camera pixels per line (two bytes each).
- V_ACTIVE, 480, camera lines per frame.
- DECIM, 2, keep every DECIM-th pixel and every DECIM-th line (1 = no decimation).
- FORMAT, 0, pixel conversion:
  - 0 = RGB444 in (byte0 xxxxRRRR, byte1 GGGGBBBB) to RGB444 out.
  - 1 = RGB565 in to RGB444 out (MSBs of each channel).
  - 2 = RGB565 in to RGB332 out (MSBs).
- PIX_W, 12, RAM data width; must be 12 for FORMAT 0/1 and 8 for FORMAT 2.
- ADDR_W, 17, RAM address width.
- Derived MEM_DEPTH = (H_ACTIVE/DECIM)*(V_ACTIVE/DECIM); default 76800.

Ports:
- PCLK  in  1  camera pixel clock; all logic on posedge.
- RST_N  in  1  asynchronous active-low reset.
- VSYNC  in  1  frame sync, high = vertical blanking.
- HREF  in  1  line valid, high = active bytes.
- D  in  8  camera data byte.
- capture_en  in  1  arm capture; sampled at frame start only.
- DP_RAM_data_in  out  PIX_W  converted pixel.
- DP_RAM_addr_in  out  ADDR_W  write address.
- DP_RAM_regW  out  1  one-cycle write strobe.
- frame_done  out  1  one-cycle pulse at end of captured frame.
- line_err  out  1  one-cycle pulse on malformed line.
- busy  out  1  high while in ARMED or ACTIVE.

Behaviour:
- Reset: all outputs 0; state IDLE; byte phase, column, row and address counters 0. Async assert, sync release.
- State machine (registered):
  - IDLE: go to ARMED when capture_en=1.
  - ARMED: go to ACTIVE on the VSYNC falling edge (VSYNC previous cycle 1, now 0). If capture_en drops, return to IDLE.
  - ACTIVE: capture. On VSYNC rising edge, pulse frame_done, then go to ARMED if capture_en=1, else IDLE.
  - A mid-frame deassert of capture_en has no effect until the frame ends.
- Byte phase:
  - Toggles on each PCLK with HREF=1 in ACTIVE; forced to 0 while HREF=0.
  - Byte0 is held in a register; byte1 completes the pixel.
- Counters:
  - col increments per completed pixel; cleared on HREF falling edge.
  - row increments on HREF falling edge; cleared on entry to ACTIVE.
- Decimation: a pixel is kept iff col%DECIM==0 and row%DECIM==0. Implement with modulo counters, no dividers.
- Write timing: for a kept pixel whose byte1 is sampled at edge k, the following are all valid at edge k+1 for exactly one cycle:
  - DP_RAM_regW=1;
  - DP_RAM_data_in = converted pixel;
  - DP_RAM_addr_in = current address.
- Address:
  - Increments by 1 in the cycle after each write; wraps to 0 on frame_done.
  - Writes at address >= MEM_DEPTH are suppressed (regW stays 0) and the address saturates at MEM_DEPTH.
  - Nothing is ever written beyond MEM_DEPTH-1.
- Outputs hold their last value when not writing.
- line_err pulses on an HREF falling edge when either:
  - byte phase is 1 (odd byte count), or
  - col != H_ACTIVE.
  The affected line still counts as a row.
- If VSYNC rises while HREF=1, the line is aborted without line_err; frame_done still pulses.
- No writes occur in IDLE or ARMED, regardless of HREF.

Optional Feature:
- Macro: CAPTURE_TEST_PATTERN_EN.
- Defined:
  - Adds input test_pattern (1 bit). When test_pattern=1, the converted pixel is replaced by 8 vertical colour bars.
  - Bar index = col*8/H_ACTIVE, mapped to white, yellow, cyan, green, magenta, red, blue, black at full scale in PIX_W format.
  - Timing, decimation and addressing are unchanged.
- Undefined: no port and no logic; D always feeds the converter.

Test Plan:
- Reset: H_ACTIVE=8, V_ACTIVE=4, DECIM=2, FORMAT=0. Assert RST_N=0 mid-line -> all outputs 0 immediately; after release, state IDLE and no regW.
- Full small frame, same parameters, capture_en=1:
  - Two VSYNC pulses; bytes 0x0A,0xBC repeated.
  - Exactly 8 writes with data 0xABC at addresses 0..7, only on even rows and columns.
  - frame_done pulses once; address returns to 0.
- Formats:
  - FORMAT=1, bytes 0xF8,0x1F -> data 0xF0F.
  - FORMAT=2, bytes 0xFF,0xE0 -> data 0xFC.
  - Both: regW asserted one cycle after byte1.
- Malformed line: HREF high for 7 bytes -> line_err pulses once at HREF fall; the next line writes continue at the correct address.
- Arming: capture_en raised mid-frame -> no writes until the next VSYNC fall. capture_en dropped mid-frame -> current frame completes, then busy=0.
- Overflow: V_ACTIVE=4 but 6 lines sent -> writes stop at address 7; address saturates at 8; no regW beyond.
